// File: rtl/aes_inv_pkg.sv
// aes_inv_pkg: shared definitions for the AES InvSubBytes/InvShiftRows block.
//   - state_t     : FSM encoding of inv_subbyte
//   - NBYTES / LAST_IDX : byte-count constants of the 128-bit AES state
//   - src_idx()   : maps output byte index to source byte index (InvShiftRows)
//   - INV_SBOX    : 256-entry inverse S-box, INV_SBOX[x] = InvSBox(x)
package aes_inv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         NBYTES   = 16;
    localparam logic [3:0] LAST_IDX = 4'd15;

    // Output byte k sits at row r = k[1:0], column c = k[3:2]. InvShiftRows
    // pulls it from column (c - r) mod 4 of the same row; 2-bit subtraction
    // gives the mod-4 wrap for free.
    function automatic logic [3:0] src_idx(input logic [3:0] k);
        logic [1:0] c_src;
        c_src = k[3:2] - k[1:0];
        return {c_src, k[1:0]};
    endfunction

    // Element 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/inv_sbox_rom.sv
// inv_sbox_rom: synchronous-read inverse AES S-box ROM.
// Ports:
//   clk     - clock
//   addr    - byte to substitute
//   chip_en - chip enable
//   read_en - read enable; data updates one cycle after chip_en & read_en
//   data    - registered InvSBox(addr); holds when not read
module inv_sbox_rom
    import aes_inv_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic       chip_en,
    input  logic       read_en,
    output logic [7:0] data
);

    logic [7:0] r_data;

    always_ff @(posedge clk) begin
        if (chip_en && read_en)
            r_data <= INV_SBOX[addr];
    end

    assign data = r_data;

endmodule

// File: rtl/inv_subbyte.sv
// inv_subbyte: computes InvSubBytes(InvShiftRows(data_in)) one byte per cycle
// through a synchronous inverse S-box. Start-to-ready latency is 18 cycles.
// Byte i of a 128-bit word is bits [127-8i -: 8].
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start_in      - request, only sampled in IDLE
//   data_in       - 128-bit AES state, latched on accept
//   sbox_data_out - external ROM address
//   sbox_data_in  - external ROM data, valid one cycle after ce/re
//   ce, re        - external ROM chip/read enable
//   data_out      - result, stable from DONE until the next accepted start
//   ready_out     - one-cycle completion pulse
// Build option: define INV_SUBBYTE_INTERNAL_SBOX_EN to use a registered
// internal table instead of the external ROM (ROM ports then tied to 0).
module inv_subbyte
    import aes_inv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [127:0] data_in,
    output logic [7:0]   sbox_data_out,
    input  logic [7:0]   sbox_data_in,
    output logic         ce,
    output logic         re,
    output logic [127:0] data_out,
    output logic         ready_out
);

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic [0:15][7:0]     r_src;     // latched input, element i = byte i
    logic [0:15][7:0]     r_dout;
    logic                 r_wr_vld;  // a lookup was issued last cycle
    logic [3:0]           r_wr_idx;  // output byte that lookup belongs to
    logic                 w_lookup;
    logic [7:0]           w_addr;
    logic [7:0]           w_rd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_in) w_next = LOOKUP;
            LOOKUP:  if (r_cnt == LAST_IDX) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_lookup  = (r_state == LOOKUP);
    assign w_addr    = r_src[src_idx(r_cnt)];
    assign ready_out = (r_state == DONE);
    assign data_out  = r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_src    <= '0;
            r_dout   <= '0;
            r_wr_vld <= 1'b0;
            r_wr_idx <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_in) begin
                r_src <= data_in;
                r_cnt <= 4'd0;
            end else if (w_lookup) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // ROM data arrives one cycle after the address, so the write
            // trails the issue by one cycle; the last one lands in DRAIN.
            r_wr_vld <= w_lookup;
            r_wr_idx <= r_cnt;
            if (r_wr_vld)
                r_dout[r_wr_idx] <= w_rd;
        end
    end

`ifdef INV_SUBBYTE_INTERNAL_SBOX_EN
    // Registered table read keeps the same one-cycle read latency as the ROM.
    logic [7:0] r_tbl;
    logic       w_unused_sbox;

    always_ff @(posedge clk) begin
        if (rst)
            r_tbl <= 8'h00;
        else if (w_lookup)
            r_tbl <= INV_SBOX[w_addr];
    end

    assign w_rd          = r_tbl;
    assign ce            = 1'b0;
    assign re            = 1'b0;
    assign sbox_data_out = 8'h00;
    assign w_unused_sbox = ^sbox_data_in;
`else
    assign ce            = w_lookup;
    assign re            = w_lookup;
    assign sbox_data_out = w_lookup ? w_addr : 8'h00;
    assign w_rd          = sbox_data_in;
`endif

endmodule
